// File: rtl/countdown_counter_ctrl.sv
// Programmable up/down counter with run/pause/load control and an internal
// prescaler. The count output feeds the binary-to-BCD converter of the
// two-digit seven-segment display path.
module countdown_counter_ctrl #(
  parameter int WIDTH      = 6,
  parameter int TICK_DIV   = 50_000_000,
  parameter int INIT_VALUE = 63,
  parameter int MAX_VALUE  = 63,
  parameter int WRAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             done
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V      = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] INIT_V     = WIDTH'(INIT_VALUE);
  localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [PW-1:0]    presc;
  logic [WIDTH-1:0] reload;
  logic             start_q;
  logic             pause_q;
  logic             load_q;

  logic             start_edge;
  logic             pause_edge;
  logic             load_edge;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] wrap_value;
  logic             at_terminal;
  logic             step_terminal;
  logic             tick;

  // Edge detection, load clamping and next-step arithmetic for the current direction
  always_comb begin
    start_edge    = start & ~start_q;
    pause_edge    = pause & ~pause_q;
    load_edge     = load & ~load_q;
    load_clamped  = (load_value > MAX_V) ? MAX_V : load_value;
    step_value    = up_down ? (count + WIDTH'(1)) : (count - WIDTH'(1));
    wrap_value    = up_down ? '0 : MAX_V;
    at_terminal   = up_down ? (count == MAX_V) : (count == '0);
    step_terminal = up_down ? (step_value == MAX_V) : (step_value == '0);
    tick          = (presc == PRESC_LAST);
  end

  // Control FSM: load beats pause beats start; otherwise RUN advances the prescaler and steps
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      count   <= INIT_V;
      reload  <= INIT_V;
      presc   <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      start_q <= 1'b0;
      pause_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      start_q <= start;
      pause_q <= pause;
      load_q  <= load;
      if (WRAP != 0) begin
        done <= 1'b0;
      end
      if (load_edge) begin
        count   <= load_clamped;
        reload  <= load_clamped;
        state   <= ST_IDLE;
        presc   <= '0;
        running <= 1'b0;
        done    <= 1'b0;
      end else if (pause_edge && (state == ST_RUN || state == ST_PAUSE)) begin
        state   <= (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        running <= (state == ST_PAUSE);
      end else if (start_edge && state != ST_RUN) begin
        case (state)
          ST_DONE: begin
            count   <= reload;
            presc   <= '0;
            done    <= 1'b0;
            state   <= ST_RUN;
            running <= 1'b1;
          end
          ST_PAUSE: begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
          default: begin
            presc <= '0;
            if (WRAP == 0 && at_terminal) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              state   <= ST_RUN;
              running <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_RUN) begin
        if (tick) begin
          presc <= '0;
          if (at_terminal) begin
            done <= 1'b1;
            if (WRAP != 0) begin
              count <= wrap_value;
            end else begin
              state   <= ST_DONE;
              running <= 1'b0;
            end
          end else begin
            count <= step_value;
            if (WRAP == 0 && step_terminal) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end else if (state == ST_IDLE || state == ST_DONE) begin
        presc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_countdown_counter_ctrl.sv
// Scoreboard bench for countdown_counter_ctrl: three instances (no wrap,
// wrap at 63, wrap at a reduced maximum of 40) share one stimulus stream.
module tb_countdown_counter_ctrl;

  localparam int TD = 4;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic       up_down = 1'b0;
  logic [5:0] load_value = '0;

  logic [5:0] count0, count1, count2;
  logic       running0, running1, running2;
  logic       done0, done1, done2;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  logic [23:0] exp_q[$];

  // Reference model: per-instance abstract state
  int p_wrap [3] = '{0, 1, 1};
  int p_max  [3] = '{63, 63, 40};
  int m_cnt  [3];
  int m_rel  [3];
  int m_st   [3];
  int m_el   [3];
  bit m_dn   [3];
  bit prev_s, prev_p, prev_l;

  always #5 clk = ~clk;

  countdown_counter_ctrl #(.WIDTH(6), .TICK_DIV(TD), .INIT_VALUE(63), .MAX_VALUE(63), .WRAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load), .load_value(load_value),
    .up_down(up_down), .count(count0), .running(running0), .done(done0));

  countdown_counter_ctrl #(.WIDTH(6), .TICK_DIV(TD), .INIT_VALUE(63), .MAX_VALUE(63), .WRAP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load), .load_value(load_value),
    .up_down(up_down), .count(count1), .running(running1), .done(done1));

  countdown_counter_ctrl #(.WIDTH(6), .TICK_DIV(TD), .INIT_VALUE(40), .MAX_VALUE(40), .WRAP(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .load(load), .load_value(load_value),
    .up_down(up_down), .count(count2), .running(running2), .done(done2));

  function automatic int terminal(int i, bit ud);
    return ud ? p_max[i] : 0;
  endfunction

  function automatic logic [7:0] pack(int i);
    return {6'(m_cnt[i]), (m_st[i] == S_RUN), m_dn[i]};
  endfunction

  // One clock of the specification's rules, applied to every instance
  task automatic model_cycle(input bit r, input bit s, input bit p, input bit l, input int lv, input bit ud);
    bit se, pe, le;
    se = s && !prev_s;
    pe = p && !prev_p;
    le = l && !prev_l;
    prev_s = r ? 1'b0 : s;
    prev_p = r ? 1'b0 : p;
    prev_l = r ? 1'b0 : l;
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        m_cnt[i] = p_max[i];
        m_rel[i] = p_max[i];
        m_st[i]  = S_IDLE;
        m_el[i]  = 0;
        m_dn[i]  = 0;
        continue;
      end
      if (p_wrap[i] != 0) m_dn[i] = 0;
      if (le) begin
        m_cnt[i] = (lv > p_max[i]) ? p_max[i] : lv;
        m_rel[i] = m_cnt[i];
        m_st[i]  = S_IDLE;
        m_el[i]  = 0;
        m_dn[i]  = 0;
      end else if (pe && (m_st[i] == S_RUN || m_st[i] == S_PAUSE)) begin
        m_st[i] = (m_st[i] == S_RUN) ? S_PAUSE : S_RUN;
      end else if (se && m_st[i] != S_RUN) begin
        if (m_st[i] == S_DONE) begin
          m_cnt[i] = m_rel[i];
          m_el[i]  = 0;
          m_dn[i]  = 0;
          m_st[i]  = S_RUN;
        end else if (m_st[i] == S_PAUSE) begin
          m_st[i] = S_RUN;
        end else if (p_wrap[i] == 0 && m_cnt[i] == terminal(i, ud)) begin
          m_st[i] = S_DONE;
          m_dn[i] = 1;
        end else begin
          m_st[i] = S_RUN;
          m_el[i] = 0;
        end
      end else if (m_st[i] == S_RUN) begin
        m_el[i]++;
        if (m_el[i] == TD) begin
          m_el[i] = 0;
          if (m_cnt[i] == terminal(i, ud)) begin
            m_dn[i] = 1;
            if (p_wrap[i] != 0) m_cnt[i] = ud ? 0 : p_max[i];
            else m_st[i] = S_DONE;
          end else begin
            m_cnt[i] = ud ? m_cnt[i] + 1 : m_cnt[i] - 1;
            if (p_wrap[i] == 0 && m_cnt[i] == terminal(i, ud)) begin
              m_st[i] = S_DONE;
              m_dn[i] = 1;
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit p, input bit l, input logic [5:0] lv, input bit ud);
    @(negedge clk);
    rst        = r;
    start      = s;
    pause      = p;
    load       = l;
    load_value = lv;
    up_down    = ud;
    model_cycle(r, s, p, l, int'(lv), ud);
    exp_q.push_back({pack(0), pack(1), pack(2)});
  endtask

  task automatic hold(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, load_value, up_down);
  endtask

  task automatic pulse(input bit s, input bit p, input bit l, input logic [5:0] lv, input bit ud);
    applyStimulus(1'b0, s, p, l, lv, ud);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, lv, ud);
  endtask

  task automatic checkOutput(input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL dut%0d cycle %0d: got count=%0d running=%0b done=%0b, expected count=%0d running=%0b done=%0b",
               idx, cycle, act[7:2], act[1], act[0], exp[7:2], exp[1], exp[0]);
    end
  endtask

  // Monitor: one expectation per clock, sampled just after the rising edge
  initial begin
    logic [23:0] e;
    forever begin
      @(posedge clk);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(0, {count0, running0, done0}, e[23:16]);
        checkOutput(1, {count1, running1, done1}, e[15:8]);
        checkOutput(2, {count2, running2, done2}, e[7:0]);
      end
    end
  end

  // Stimulus: directed scenarios, then randomized control traffic
  initial begin
    bit r_r, r_s, r_p, r_l, r_ud;
    logic [5:0] r_lv;
    int drain;
    // reset, with a start edge inside reset that must be ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);
    hold(3);
    // count down from 63 to 0, then dwell
    pulse(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    hold(63 * TD + 25);
    // restart from DONE, then mid-run load of 10 and restart
    pulse(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    hold(18);
    pulse(1'b0, 1'b0, 1'b1, 6'b001010, 1'b0);
    hold(3);
    pulse(1'b1, 1'b0, 1'b0, 6'b001010, 1'b0);
    hold(2 * TD + 2);
    // pause in the middle of a step period, hold, resume
    pulse(1'b0, 1'b1, 1'b0, 6'b001010, 1'b0);
    hold(10);
    pulse(1'b0, 1'b1, 1'b0, 6'b001010, 1'b0);
    hold(2 * TD);
    // count up from 62 to the terminal
    pulse(1'b0, 1'b0, 1'b1, 6'd62, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 6'd62, 1'b1);
    hold(3 * TD + 3);
    // start while already at the terminal
    pulse(1'b0, 1'b0, 1'b1, 6'd0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'd0, 1'b0);
    hold(2 * TD);
    // load and start together, start held, then a fresh start edge
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'b000111, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'b000111, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 6'b000111, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 6'b000111, 1'b0);
    hold(TD + 2);
    // randomized traffic
    r_ud = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      r_r  = ($urandom_range(0, 599) == 0);
      r_s  = ($urandom_range(0, 11) == 0);
      r_p  = ($urandom_range(0, 24) == 0);
      r_l  = ($urandom_range(0, 79) == 0);
      r_lv = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 39) == 0) r_ud = ~r_ud;
      applyStimulus(r_r, r_s, r_p, r_l, r_lv, r_ud);
    end
    hold(2);
    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      @(posedge clk);
      drain++;
    end
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
